// File: rtl/evo_pcc_tx.sv
// evo_pcc_tx: burst transmitter driving the PCC parallel-capture bus {den1, den2, clk, data[13:0]} from a valid/ready word stream
module evo_pcc_tx #(
   parameter int HALF_CYC = 2,
   parameter int GAP_CYC  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [10:0] cfg_flit_cnt_i,
   input  logic [9:0]  cfg_burst_cnt_i,
   input  logic [13:0] in_data_i,
   input  logic        in_vld_i,
   output logic        in_rdy_o,
   output logic [16:0] pcc_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        aborted_o
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_GAP, S_DONE} state_t;
   localparam int CW = $clog2((HALF_CYC > GAP_CYC ? HALF_CYC : GAP_CYC) + 1);

   state_t        r_state, w_nxt;
   logic [CW-1:0] r_cnt;
   logic [10:0]   r_cfg_flit, r_flit;
   logic [9:0]    r_burst;
   logic [13:0]   r_data;
   logic          r_pcc_clk, r_rdy, r_busy, r_done, r_aborted;
   logic          w_abort, w_half_end, w_gap_end;

   assign w_abort    = abort_i && r_state != S_IDLE;
   assign w_half_end = r_cnt == CW'(HALF_CYC - 1);
   assign w_gap_end  = r_cnt == CW'(GAP_CYC - 1);

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_nxt = (cfg_flit_cnt_i == '0 || cfg_burst_cnt_i == '0) ? S_DONE : S_LOAD;
         S_LOAD:  if (in_vld_i) w_nxt = S_LOW;
         S_LOW:   if (w_half_end) w_nxt = S_HIGH;
         S_HIGH:  if (w_half_end) w_nxt = r_flit != 11'd1 ? S_LOAD : r_burst != 10'd1 ? S_GAP : S_DONE;
         S_GAP:   if (w_gap_end) w_nxt = S_LOAD;
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      if (w_abort) w_nxt = S_IDLE;
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_cfg_flit <= '0;
         r_flit     <= '0;
         r_burst    <= '0;
         r_data     <= '0;
         r_pcc_clk  <= 1'b0;
         r_rdy      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= (w_nxt == r_state) ? r_cnt + 1'b1 : '0;
         if (r_state == S_IDLE && start_i) begin
            r_cfg_flit <= cfg_flit_cnt_i;
            r_flit     <= cfg_flit_cnt_i;
            r_burst    <= cfg_burst_cnt_i;
         end else if (r_state == S_HIGH && w_half_end) begin
            r_flit  <= r_flit != 11'd1 ? r_flit - 11'd1 : r_cfg_flit;
            r_burst <= r_flit != 11'd1 ? r_burst : r_burst - 10'd1;
         end
         if (r_state == S_LOAD && w_nxt == S_LOW) r_data <= in_data_i;
         r_pcc_clk <= w_nxt == S_HIGH;
         r_rdy     <= w_nxt == S_LOAD;
         r_busy    <= w_nxt inside {S_LOAD, S_LOW, S_HIGH, S_GAP};
         r_done    <= w_nxt == S_DONE;
         r_aborted <= w_abort;
      end
   end

   assign pcc_o     = {2'b00, r_pcc_clk, r_data};
   assign in_rdy_o  = r_rdy;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign aborted_o = r_aborted;
endmodule

// File: tb/tb_evo_pcc_tx.sv
// tb_evo_pcc_tx: directed and randomized bench for evo_pcc_tx, checked every cycle against a procedural transfer model
module tb_evo_pcc_tx;
   localparam int H = 2;
   localparam int G = 4;

   logic        clk = 1'b0, reset_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, in_vld_i = 1'b0;
   logic [10:0] cfg_flit_cnt_i = '0;
   logic [9:0]  cfg_burst_cnt_i = '0;
   logic [13:0] in_data_i = '0;
   logic        in_rdy_o, busy_o, done_o, aborted_o;
   logic [16:0] pcc_o;

   evo_pcc_tx #(.HALF_CYC(H), .GAP_CYC(G)) dut (
      .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
      .cfg_flit_cnt_i(cfg_flit_cnt_i), .cfg_burst_cnt_i(cfg_burst_cnt_i),
      .in_data_i(in_data_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
      .pcc_o(pcc_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        exp_clk = 1'b0, exp_rdy = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_abt = 1'b0;
   logic [13:0] exp_data = '0;

   task automatic adv(output bit k);
      @(posedge clk);
      exp_done = 1'b0;
      exp_abt  = 1'b0;
      k = 1'b1;
      if (!reset_n) begin
         exp_clk = 1'b0; exp_data = '0; exp_rdy = 1'b0; exp_busy = 1'b0;
      end else if (abort_i) begin
         exp_clk = 1'b0; exp_rdy = 1'b0; exp_busy = 1'b0; exp_abt = 1'b1;
      end else k = 1'b0;
   endtask

   // A transfer is played out as nested burst/flit loops; k marks an abort or reset cutting it short.
   initial begin : model
      bit k;
      int nf, nb;
      forever begin
         @(posedge clk);
         exp_done = 1'b0;
         exp_abt  = 1'b0;
         if (!reset_n) begin
            exp_clk = 1'b0; exp_data = '0; exp_rdy = 1'b0; exp_busy = 1'b0;
         end else if (start_i) begin
            nf = int'(cfg_flit_cnt_i);
            nb = int'(cfg_burst_cnt_i);
            k  = 1'b0;
            if (nf > 0 && nb > 0) begin
               exp_busy = 1'b1;
               for (int b = 0; b < nb && !k; b++) begin
                  for (int g = 0; g < G && b > 0 && !k; g++) adv(k);
                  for (int f = 0; f < nf && !k; f++) begin
                     exp_rdy = 1'b1;
                     do adv(k); while (!k && !in_vld_i);
                     if (!k) begin exp_rdy = 1'b0; exp_data = in_data_i; end
                     for (int i = 0; i < H && !k; i++) adv(k);
                     if (!k) exp_clk = 1'b1;
                     for (int i = 0; i < H && !k; i++) adv(k);
                     if (!k) exp_clk = 1'b0;
                  end
               end
            end
            if (!k) begin exp_busy = 1'b0; exp_done = 1'b1; adv(k); end
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;
   logic [13:0] rise_d[$];
   int rise_low[$], rise_stab[$], done_q[$];
   int low_run = 0, stab = 0, rdy_tot = 0, t0 = 0, rq0 = 0, dq0 = 0, r0 = 0;
   logic prev_clk = 1'b0, prev_rdy = 1'b0;
   logic [13:0] prev_data = '0, word = '0;
   bit rnd_vld = 1'b0, stall_armed = 1'b0;
   int hs_cnt = 0, stall_at = 0, stall_left = 0;

   task automatic chk(string name, int act, int want);
      n_chk++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic tick();
      logic [20:0] act, want;
      @(negedge clk);
      act  = {busy_o, in_rdy_o, done_o, aborted_o, pcc_o};
      want = {exp_busy, exp_rdy, exp_done, exp_abt, 2'b00, exp_clk, exp_data};
      if (chk_en) chk("per_cycle_outputs", int'(act), int'(want));
      if (pcc_o[14] && !prev_clk) begin
         rise_d.push_back(pcc_o[13:0]);
         rise_low.push_back(low_run);
         rise_stab.push_back(pcc_o[13:0] == prev_data ? stab : -1);
      end
      if (!pcc_o[14]) stab = (!prev_clk && pcc_o[13:0] == prev_data) ? stab + 1 : 1;
      else stab = 0;
      low_run = pcc_o[14] ? 0 : low_run + 1;
      if (done_o) done_q.push_back(cyc);
      rdy_tot += int'(in_rdy_o);
      prev_clk  = pcc_o[14];
      prev_data = pcc_o[13:0];
      start_i = 1'b0;
      abort_i = 1'b0;
      reset_n = 1'b1;
      if (in_vld_i && prev_rdy) begin
         word++;
         hs_cnt++;
         if (stall_armed && hs_cnt == stall_at) begin stall_left = 10; stall_armed = 1'b0; end
      end else if (stall_left > 0) stall_left--;
      prev_rdy  = in_rdy_o;
      in_data_i = word;
      in_vld_i  = stall_left == 0 && (!rnd_vld || $urandom_range(0, 3) != 0);
   endtask

   task automatic go(int f, int b, int w);
      word = 14'(w);
      in_data_i = word;
      cfg_flit_cnt_i  = 11'(f);
      cfg_burst_cnt_i = 10'(b);
      start_i = 1'b1;
      t0  = cyc;
      rq0 = rise_d.size();
      dq0 = done_q.size();
      r0  = rdy_tot;
   endtask

   task automatic wait_end(int limit);
      int t = 0;
      do begin tick(); t++; end while (!(done_o || aborted_o) && t < limit);
      chk("end_of_transfer_seen", int'(done_o || aborted_o), 1);
   endtask

   function automatic int done_rel();
      return done_q.size() > dq0 ? done_q[dq0] - t0 : -1;
   endfunction

   initial begin
      int bad;
      repeat (3) begin tick(); reset_n = 1'b0; end
      chk_en = 1'b1;
      tick();
      chk("reset_outputs", int'({busy_o, in_rdy_o, done_o, aborted_o, pcc_o}), 0);
      repeat (3) tick();

      go(4, 1, 1);
      wait_end(100);
      chk("f4_rises", rise_d.size() - rq0, 4);
      for (int i = 0; i < 4 && rq0 + i < rise_d.size(); i++) begin
         chk("f4_data", int'(rise_d[rq0 + i]), i + 1);
         chk("f4_stable_before_rise", rise_stab[rq0 + i], 2);
      end
      chk("f4_done_cycle", done_rel(), 21);
      chk("f4_rdy_cycles", rdy_tot - r0, 4);
      repeat (5) tick();

      go(2, 3, 1);
      wait_end(200);
      chk("b3_rises", rise_d.size() - rq0, 6);
      for (int i = 1; i < 6 && rq0 + i < rise_d.size(); i++)
         chk("b3_low_between_rises", rise_low[rq0 + i], (i % 2 == 0) ? 3 + G : 3);
      chk("b3_done_cycle", done_rel(), 39);
      repeat (10) tick();
      chk("b3_done_once", done_q.size() - dq0, 1);

      hs_cnt = 0; stall_at = 1; stall_armed = 1'b1;
      go(3, 1, 1);
      wait_end(200);
      chk("stall_rises", rise_d.size() - rq0, 3);
      for (int i = 0; i < 3 && rq0 + i < rise_d.size(); i++) chk("stall_data_order", int'(rise_d[rq0 + i]), i + 1);
      if (rise_low.size() > rq0 + 1) chk("stall_low_run", rise_low[rq0 + 1], 9);
      repeat (5) tick();

      go(1024, 1, 1);
      wait_end(6000);
      chk("f1024_rises", rise_d.size() - rq0, 1024);
      bad = 0;
      for (int i = 0; i < 1024 && rq0 + i < rise_d.size(); i++) if (int'(rise_d[rq0 + i]) != i + 1) bad++;
      chk("f1024_data_order", bad, 0);
      chk("f1024_done_cycle", done_rel(), 5121);
      repeat (5) tick();

      go(8, 1, 1);
      repeat (9) tick();
      chk("abort_in_second_high", int'(pcc_o[14]), 1);
      abort_i = 1'b1;
      tick();
      chk("abort_pcc_clk", int'(pcc_o[14]), 0);
      chk("abort_pulse", int'(aborted_o), 1);
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_data_held", int'(pcc_o[13:0]), 2);
      repeat (5) tick();
      chk("abort_no_done", done_q.size() - dq0, 0);
      go(1, 1, 3);
      wait_end(50);
      chk("post_abort_rises", rise_d.size() - rq0, 1);
      if (rise_d.size() > rq0) chk("post_abort_data", int'(rise_d[rq0]), 3);
      chk("post_abort_done_cycle", done_rel(), 6);
      repeat (5) tick();

      go(0, 3, 7);
      wait_end(10);
      chk("f0_done_cycle", done_rel(), 1);
      repeat (5) tick();
      chk("f0_no_rises", rise_d.size() - rq0, 0);
      chk("f0_no_rdy", rdy_tot - r0, 0);
      go(5, 0, 7);
      wait_end(10);
      chk("b0_done_cycle", done_rel(), 1);
      repeat (5) tick();

      go(4, 2, 1);
      repeat (7) tick();
      chk("rst_pre_busy", int'(busy_o), 1);
      reset_n = 1'b0;
      tick();
      chk("rst_mid_outputs", int'({busy_o, in_rdy_o, done_o, aborted_o, pcc_o}), 0);
      repeat (30) tick();
      chk("rst_no_done", done_q.size() - dq0, 0);

      rnd_vld = 1'b1;
      repeat (4000) begin
         tick();
         cfg_flit_cnt_i  = $urandom_range(0, 19) == 0 ? 11'd0 : 11'($urandom_range(1, 6));
         cfg_burst_cnt_i = $urandom_range(0, 19) == 0 ? 10'd0 : 10'($urandom_range(1, 3));
         if ($urandom_range(0, 11) == 0) start_i = 1'b1;
         if ($urandom_range(0, 149) == 0) abort_i = 1'b1;
         if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
      end
      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/evo_pcc_tx.md
# evo_pcc_tx

Burst transmitter that drives the `evo_pcc_t` parallel-capture bus toward the SAMD PCC receiver. It takes 14-bit words from an upstream valid/ready stream and emits them as flits with a strobe on `pcc.clk`. Transfers are organised into `burst_cnt` bursts of `flit_cnt` flits each, with a fixed idle gap between bursts. It sits in evo_core between the DMA/data source and the top-level PCC pins, and uses `evo_bsp_pkg` types (`evo_pcc_t`, `evo_pcc_flit_cnt_t`, `evo_pcc_burst_cnt_t`).

## Interface
Parameters:
- `HALF_CYC`, default 2: `pcc.clk` low-phase and high-phase length, in `clk` cycles; legal range ≥1.
- `GAP_CYC`, default 4: idle cycles between bursts (clk held 0); legal range ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous active-low reset
- `start_i`  in  1  one-cycle pulse; begins a transfer when idle
- `abort_i`  in  1  terminate the transfer in progress
- `cfg_flit_cnt_i`  in  `evo_pcc_flit_cnt_t` (11)  flits per burst, 0..1024
- `cfg_burst_cnt_i`  in  `evo_pcc_burst_cnt_t` (10)  bursts per transfer, 0..512
- `in_data_i`  in  14  word to transmit
- `in_vld_i`  in  1  `in_data_i` valid
- `in_rdy_o`  out  1  word accepted when `in_vld_i & in_rdy_o`
- `pcc_o`  out  `evo_pcc_t` (17)  bus: `den1`, `den2`, `clk`, `data[13:0]`
- `busy_o`  out  1  transfer in progress
- `done_o`  out  1  one-cycle pulse on normal completion
- `aborted_o`  out  1  one-cycle pulse on abort completion

## Operation
- Reset values: `pcc_o` = all 0, `in_rdy_o`=0, `busy_o`=0, `done_o`=0, `aborted_o`=0. Reset mid-transfer returns to IDLE on the next edge with these values; no done or aborted pulse is generated.
- `den1` and `den2` are tied to 0 permanently.
- States:
  - IDLE: `busy_o`=0.
  - LOAD: `in_rdy_o`=1, `pcc.clk`=0, data holds its last value.
  - LOW: `pcc.clk`=0, new data stable; lasts `HALF_CYC` cycles.
  - HIGH: `pcc.clk`=1; lasts `HALF_CYC` cycles.
  - GAP: `pcc.clk`=0; lasts `GAP_CYC` cycles.
  - DONE: one cycle with `done_o`=1.
- IDLE behaviour on `start_i`:
  - Latches both cfg counts.
  - If either count is 0, goes to DONE (no flits sent).
  - Otherwise goes to LOAD.
- `start_i` is ignored outside IDLE; cfg inputs are sampled only at start.
- LOAD: on handshake, registers `in_data_i` into `pcc.data` and goes to LOW. With no valid word it waits indefinitely: the strobe does not toggle, so the receiver stalls naturally and there is no underrun error.
- After HIGH, the counters decide the next state:
  - Flit remaining in the burst: LOAD.
  - Burst complete with bursts remaining: GAP, then LOAD.
  - Last flit of last burst: DONE.
- Counters: flit down-counter reloads from the latched count at each burst start; burst down-counter decrements at end of each burst. A count of 1024 flits must not wrap (11-bit counter).
- `abort_i` in any non-IDLE state:
  - Next cycle: `pcc.clk`=0, `aborted_o`=1, `busy_o`=0, state IDLE.
  - `pcc.data` holds its value; `done_o` is not pulsed.
  - Abort has priority over every other transition; abort in IDLE is ignored.
- Data changes only on the edge entering LOW, i.e. only while `pcc.clk`=0. Data is never changed in the same cycle `pcc.clk` rises.

## Timing
- `pcc_o`, `in_rdy_o`, `busy_o`, `done_o` and `aborted_o` are all registered.
- With `start_i` at cycle 0 and a word always valid:
  - LOAD at cycle 1; handshake at cycle 1.
  - Data on the bus at cycle 2, `pcc.clk` low during cycles 2..1+H.
  - `pcc.clk` high during cycles 2+H..1+2H; next LOAD at 2+2H.
- Flit period with data ready: 1+2·`HALF_CYC` cycles. Defaults: 5 cycles.
- Transfer length with data always ready: B·F·(1+2H) + (B−1)·GAP_CYC cycles from the first LOAD. `done_o` is asserted in the cycle after the last HIGH cycle; `busy_o` falls in the same cycle.
- `busy_o`=1 from the cycle after the accepted start through the last HIGH cycle. It is 0 during DONE.

## Test plan
- Defaults, F=4, B=1, words 0x0001..0x0004 always valid → 4 rising edges of `pcc.clk` with data 1,2,3,4 stable 2 cycles before each rise; `done_o` at cycle 21; `in_rdy_o` high in 4 cycles only.
- F=2, B=3 → 6 flits; `pcc.clk` held 0 for exactly 4 cycles after flits 2 and 4; `done_o` once.
- F=3, B=1, `in_vld_i` dropped for 10 cycles before flit 2 → `pcc.clk` stays 0 and data stays flit 1 for the stall; all 3 flits delivered in order.
- F=1024, B=1 → exactly 1024 strobes, no counter wrap; `done_o` after the 1024th HIGH phase.
- `abort_i` during the second HIGH phase of F=8 → next cycle `pcc.clk`=0, `aborted_o`=1, `busy_o`=0, no `done_o`. A following start with F=1,B=1 transmits normally.
- F=0 start → `done_o` at cycle 1, no strobes, `in_rdy_o` never high. `reset_n`=0 mid-burst → all outputs 0 next cycle.
